// File: rtl/spi_slave_receiver_pkg.sv
// Shared constants and FSM encoding for the SPI slave receiver.
package spi_slave_receiver_pkg;

    localparam int unsigned DEFAULT_WORD_WIDTH  = 32;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_WAIT_CS = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus a rise/fall detector.
module spi_sync_edge
    import spi_slave_receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Preset to the idle level of the line so reset never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
            prev_q <= RESET_VALUE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI mode-0 slave: receives one WORD_WIDTH frame per chip-select and shifts out TxWord.
module spi_slave_receiver
    import spi_slave_receiver_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = DEFAULT_WORD_WIDTH,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sClk,
    input  logic                  SPI_CS,
    input  logic                  MOSI,
    input  logic [WORD_WIDTH-1:0] TxWord,
    output logic [WORD_WIDTH-1:0] FromSPI,
    output logic                  valid,
    output logic                  frame_error,
    output logic                  busy,
    output logic                  MISO
);

    localparam int unsigned CNT_W    = $clog2(WORD_WIDTH) + 1;
    localparam int unsigned RX_W     = WORD_WIDTH - 1;
    localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]    LAST_BIT    = CNT_W'(WORD_WIDTH - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

    logic sclk_level, sclk_rise_c, sclk_fall_c;
    logic cs_level, cs_rise_c, cs_fall_c;
    logic mosi_level, mosi_rise_c, mosi_fall_c;
    logic lint_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(sClk),
        .level(sclk_level), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(SPI_CS),
        .level(cs_level), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(MOSI),
        .level(mosi_level), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
    );

    assign lint_unused = ^{sclk_level, mosi_rise_c, mosi_fall_c};

    spi_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RX_W-1:0]       rx_q, rx_d;
    logic [WORD_WIDTH-1:0] tx_q, tx_d;
    logic [WORD_WIDTH-1:0] from_q, from_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  busy_q;
    logic                  err_seen_q, err_seen_d;
    logic                  armed_q, armed_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;

    // A frame may only start once chip-select has been seen high after the
    // synchronizers have flushed, so a reset taken mid-frame cannot resume it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        from_d     = from_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        err_seen_d = err_seen_q;
        armed_d    = armed_q;
        settle_d   = settle_q;

        if (settle_q != SETTLE_DONE) begin
            settle_d = settle_q + SETTLE_W'(1);
        end else if (cs_level) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_c && armed_q) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = '0;
                    rx_d       = '0;
                    tx_d       = TxWord;
                    err_seen_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (sclk_fall_c) begin
                    tx_d = {tx_q[WORD_WIDTH-2:0], 1'b0};
                end
                if (sclk_rise_c) begin
                    rx_d  = RX_W'({rx_q, mosi_level});
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (sclk_rise_c && (cnt_q == LAST_BIT)) begin
                    from_d  = {rx_q, mosi_level};
                    valid_d = 1'b1;
                    state_d = cs_rise_c ? ST_IDLE : ST_WAIT_CS;
                end else if (cs_rise_c) begin
                    ferr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_CS: begin
                if (sclk_rise_c && !err_seen_q) begin
                    ferr_d     = 1'b1;
                    err_seen_d = 1'b1;
                end
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clearing TX on the way to IDLE holds MISO low while deselected.
        if (state_d == ST_IDLE) begin
            tx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            from_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_seen_q <= 1'b0;
            armed_q    <= 1'b0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            from_q     <= from_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            busy_q     <= (state_d != ST_IDLE);
            err_seen_q <= err_seen_d;
            armed_q    <= armed_d;
            settle_q   <= settle_d;
        end
    end

    assign FromSPI     = from_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign busy        = busy_q;
    assign MISO        = tx_q[WORD_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Scoreboard bench for spi_slave_receiver: SPI master model at clk/8, words checked on valid.
module tb_spi_slave_receiver;

    localparam int unsigned W  = 32;
    localparam int unsigned SS = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sClk = 1'b0;
    logic         SPI_CS = 1'b1;
    logic         MOSI = 1'b0;
    logic [W-1:0] TxWord = '0;
    logic [W-1:0] FromSPI;
    logic         valid;
    logic         frame_error;
    logic         busy;
    logic         MISO;

    spi_slave_receiver #(.WORD_WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .sClk(sClk), .SPI_CS(SPI_CS), .MOSI(MOSI),
        .TxWord(TxWord), .FromSPI(FromSPI), .valid(valid),
        .frame_error(frame_error), .busy(busy), .MISO(MISO)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_rise_cyc = 0;
    int           valid_cnt = 0;
    int           ferr_cnt = 0;
    int           v0, f0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] miso_word = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every valid cycle pops one expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    chk("rx_word", FromSPI, exp_q.pop_front());
                    chk("valid_latency", 32'((cyc - last_rise_cyc) <= int'(SS + 3)), 32'd1);
                end
            end
            if (frame_error) ferr_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        MOSI = b;
        tick(4);
        miso_word = {miso_word[W-2:0], MISO};
        sClk = 1'b1;
        last_rise_cyc = cyc;
        tick(4);
        sClk = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[W-1-i]);
    endtask

    task automatic cs_low(input logic [W-1:0] tx);
        TxWord = tx;
        SPI_CS = 1'b0;
        tick(8);
    endtask

    task automatic cs_high();
        tick(4);
        SPI_CS = 1'b1;
        tick(8);
    endtask

    initial begin
        reset = 1'b1;
        tick(4);
        chk("rst_from", FromSPI, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ferr", 32'(frame_error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_miso", 32'(MISO), 32'd0);
        reset = 1'b0;
        tick(SS + 4);

        // Plain frame, also capturing the response stream.
        v0 = valid_cnt; f0 = ferr_cnt; miso_word = '0;
        exp_q.push_back(32'hB38F0F82);
        cs_low(32'h12345678);
        chk("s1_busy", 32'(busy), 32'd1);
        send_bits(32'hB38F0F82, 32);
        cs_high();
        chk("s1_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("s1_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        chk("s1_from", FromSPI, 32'hB38F0F82);
        chk("s1_miso_word", miso_word, 32'h12345678);

        miso_word = '0;
        exp_q.push_back(32'h0F0F1234);
        cs_low(32'hA5A5003C);
        send_bits(32'h0F0F1234, 32);
        cs_high();
        chk("s2_miso_word", miso_word, 32'hA5A5003C);
        chk("s2_miso_idle", 32'(MISO), 32'd0);
        chk("s2_busy_idle", 32'(busy), 32'd0);

        // Aborted frame after 17 bits.
        v0 = valid_cnt; f0 = ferr_cnt;
        cs_low(32'hFFFF0000);
        send_bits(32'hDEADBEEF, 17);
        cs_high();
        chk("s3_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        chk("s3_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
        chk("s3_from_kept", FromSPI, 32'h0F0F1234);
        chk("s3_busy", 32'(busy), 32'd0);

        // Overlong frame: 33 clocks.
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_q.push_back(32'hC0FFEE11);
        cs_low(32'h0);
        send_bits(32'hC0FFEE11, 32);
        send_bit(1'b1);
        cs_high();
        chk("s4_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("s4_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
        chk("s4_from", FromSPI, 32'hC0FFEE11);

        // Reset mid-frame, clocks continue with CS still low, then a fresh frame.
        v0 = valid_cnt; f0 = ferr_cnt;
        cs_low(32'h0);
        send_bits(32'hFFFFFFFF, 10);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(SS + 4);
        send_bits(32'hFFFFFFFF, 3);
        chk("s5_busy_after_rst", 32'(busy), 32'd0);
        cs_high();
        chk("s5_abort_valid", 32'(valid_cnt - v0), 32'd0);
        chk("s5_abort_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("s5_from_rst", FromSPI, 32'h0);
        exp_q.push_back(32'h00000001);
        cs_low(32'h0);
        send_bits(32'h00000001, 32);
        cs_high();
        chk("s5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("s5_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        chk("s5_from", FromSPI, 32'h00000001);

        // Back-to-back frames with CS high for only 4 clk.
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_q.push_back(32'hFFFFFFFF);
        exp_q.push_back(32'h00000000);
        cs_low(32'h0);
        send_bits(32'hFFFFFFFF, 32);
        tick(4);
        SPI_CS = 1'b1;
        tick(4);
        SPI_CS = 1'b0;
        tick(8);
        send_bits(32'h00000000, 32);
        cs_high();
        chk("s6_valid_cnt", 32'(valid_cnt - v0), 32'd2);
        chk("s6_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);

        // CS rises together with the final sClk rise: frame still completes.
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_q.push_back(32'h5A5AC3C3);
        cs_low(32'h0);
        send_bits(32'h5A5AC3C3, 31);
        MOSI = 1'b1;
        tick(4);
        sClk = 1'b1;
        SPI_CS = 1'b1;
        last_rise_cyc = cyc;
        tick(4);
        sClk = 1'b0;
        tick(8);
        chk("s7_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("s7_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        chk("s7_busy", 32'(busy), 32'd0);
        chk("s7_from", FromSPI, 32'h5A5AC3C3);

        // sClk rise coincident with CS fall must not count as a bit.
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_q.push_back(32'h000000FF);
        TxWord = '0;
        MOSI = 1'b1;
        SPI_CS = 1'b0;
        sClk = 1'b1;
        tick(4);
        sClk = 1'b0;
        tick(4);
        send_bits(32'h000000FF, 32);
        cs_high();
        chk("s8_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("s8_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        chk("s8_from", FromSPI, 32'h000000FF);

        tick(10);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
